// File: rtl/card_grid_pkg.sv
// Shared definitions for the card-merge grid: FSM states, button bit
// positions and an index-width helper that stays >= 1 for tiny grids.
package card_grid_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grid_cursor.sv
// Wrap-around grid cursor. One move per cycle, priority up > down > left > right.
// Up/down wrap within the column; left/right wrap linearly across the grid.
module grid_cursor
    import card_grid_pkg::*;
#(
    parameter int unsigned ROWS = 2,
    parameter int unsigned COLS = 5,
    localparam int unsigned N  = ROWS * COLS,
    localparam int unsigned CW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    buttons,
    output logic [CW-1:0] cursor
);

    logic [CW-1:0] cursor_next;
    int unsigned   cur;
    int unsigned   nxt;

    // Next cursor position from the highest-priority move pulse.
    always_comb begin
        cur = 32'(cursor);
        nxt = cur;
        if (buttons[BTN_UP]) begin
            nxt = (cur < COLS) ? cur + (ROWS - 1) * COLS : cur - COLS;
        end else if (buttons[BTN_DOWN]) begin
            nxt = (cur >= (ROWS - 1) * COLS) ? cur - (ROWS - 1) * COLS : cur + COLS;
        end else if (buttons[BTN_LEFT]) begin
            nxt = (cur == 0) ? N - 1 : cur - 1;
        end else if (buttons[BTN_RIGHT]) begin
            nxt = (cur == N - 1) ? 0 : cur + 1;
        end
        cursor_next = CW'(nxt);
    end

    // Cursor register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor <= '0;
        end else begin
            cursor <= cursor_next;
        end
    end

endmodule

// File: rtl/card_merge_grid.sv
// Card-merge engine: grid storage, two-step select/merge FSM and a
// modular adder built from conditional subtractions (no divider).
// Optional macro CARD_CLEAR_EN: a merge also zeroes the second (cursor) card.
module card_merge_grid
    import card_grid_pkg::*;
#(
    parameter int unsigned ROWS    = 2,
    parameter int unsigned COLS    = 5,
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned N  = ROWS * COLS,
    localparam int unsigned CW = idx_w(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             buttons,
    input  logic                   btn,
    input  logic                   load,
    input  logic [N*DIGIT_W-1:0]   load_data,
    output logic [N*DIGIT_W-1:0]   status,
    output logic [CW-1:0]          cursor,
    output logic                   sel_valid,
    output logic [CW-1:0]          sel_index,
    output logic                   merge_done,
    output logic [CNT_W-1:0]       merge_count
);

    // Operands are not pre-reduced, so the raw sum may need several
    // subtractions; the bound covers the largest possible sum.
    localparam int unsigned     MAX_SUB = ((2 ** (DIGIT_W + 1)) - 2) / MODULUS;
    localparam logic [DIGIT_W:0] MOD_V  = (DIGIT_W + 1)'(MODULUS);

    logic [DIGIT_W-1:0] grid [N];
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] merged;
    state_t             state;

    grid_cursor #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cursor (
        .clk     (clk),
        .rst_n   (rst_n),
        .buttons (buttons),
        .cursor  (cursor)
    );

    // Pack the grid onto the status bus, cell k at [k*DIGIT_W +: DIGIT_W].
    always_comb begin
        status = '0;
        for (int unsigned i = 0; i < N; i++) begin
            status[i*DIGIT_W +: DIGIT_W] = grid[i];
        end
    end

    // Modular sum of held card and cursor card.
    always_comb begin
        sum = {1'b0, grid[sel_index]} + {1'b0, grid[cursor]};
        for (int unsigned i = 0; i < MAX_SUB; i++) begin
            if (sum >= MOD_V) begin
                sum = sum - MOD_V;
            end
        end
        merged = sum[DIGIT_W-1:0];
    end

    // Select/merge FSM, grid writes and merge bookkeeping; load beats btn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                grid[i] <= '0;
            end
            state       <= IDLE;
            sel_valid   <= 1'b0;
            sel_index   <= '0;
            merge_done  <= 1'b0;
            merge_count <= '0;
        end else begin
            merge_done <= 1'b0;
            if (load) begin
                for (int unsigned i = 0; i < N; i++) begin
                    grid[i] <= load_data[i*DIGIT_W +: DIGIT_W];
                end
                state     <= IDLE;
                sel_valid <= 1'b0;
                sel_index <= '0;
            end else if (btn) begin
                case (state)
                    IDLE: begin
                        sel_index <= cursor;
                        sel_valid <= 1'b1;
                        state     <= HELD;
                    end
                    HELD: begin
                        if (cursor != sel_index) begin
                            grid[sel_index] <= merged;
`ifdef CARD_CLEAR_EN
                            grid[cursor] <= '0;
`endif
                            merge_done <= 1'b1;
                            if (merge_count != '1) begin
                                merge_count <= merge_count + 1'b1;
                            end
                        end
                        sel_valid <= 1'b0;
                        sel_index <= '0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_merge_grid.sv
// Self-checking bench for card_merge_grid: default 2x5 decimal grid plus a
// 3x4, 5-bit, mod-17 instance with a 2-bit merge counter.
module tb_card_merge_grid;

    localparam int ROWS = 2, COLS = 5, N = 10;
    localparam int R2 = 3, C2 = 4, N2 = 12;

    logic        clk;
    logic        rst_n, btn, load;
    logic [3:0]  buttons;
    logic [39:0] load_data, status;
    logic [3:0]  cursor, sel_index;
    logic        sel_valid, merge_done;
    logic [7:0]  merge_count;

    logic        rst_n2, btn2, load2;
    logic [3:0]  buttons2;
    logic [59:0] load_data2, status2;
    logic [3:0]  cursor2, sel_index2;
    logic        sel_valid2, merge_done2;
    logic [1:0]  merge_count2;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] e;

    int mg[N];
    int mg2[N2];
    int mcur, mcur2, mcount, mcount2;

    card_merge_grid #(.ROWS(2), .COLS(5), .DIGIT_W(4), .MODULUS(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .btn(btn), .load(load),
        .load_data(load_data), .status(status), .cursor(cursor),
        .sel_valid(sel_valid), .sel_index(sel_index),
        .merge_done(merge_done), .merge_count(merge_count)
    );

    card_merge_grid #(.ROWS(3), .COLS(4), .DIGIT_W(5), .MODULUS(17), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .buttons(buttons2), .btn(btn2), .load(load2),
        .load_data(load_data2), .status(status2), .cursor(cursor2),
        .sel_valid(sel_valid2), .sel_index(sel_index2),
        .merge_done(merge_done2), .merge_count(merge_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_cur(input int c, input logic [3:0] b, input int rows, input int cols);
        int row, col;
        row = c / cols;
        col = c % cols;
        if (b[0]) row = (row + rows - 1) % rows;
        else if (b[1]) row = (row + 1) % rows;
        else if (b[2]) return (c + rows * cols - 1) % (rows * cols);
        else if (b[3]) return (c + 1) % (rows * cols);
        return row * cols + col;
    endfunction

    function automatic logic [39:0] pack1();
        logic [39:0] p;
        for (int i = 0; i < N; i++) p[i*4 +: 4] = 4'(mg[i]);
        return p;
    endfunction

    function automatic logic [59:0] pack2();
        logic [59:0] p;
        for (int i = 0; i < N2; i++) p[i*5 +: 5] = 5'(mg2[i]);
        return p;
    endfunction

    task automatic step(input logic [3:0] b, input logic bt, input logic ld);
        buttons = b; btn = bt; load = ld;
        @(posedge clk); #1;
        buttons = '0; btn = 1'b0; load = 1'b0;
        mcur = next_cur(mcur, b, ROWS, COLS);
    endtask

    task automatic step2(input logic [3:0] b, input logic bt, input logic ld);
        buttons2 = b; btn2 = bt; load2 = ld;
        @(posedge clk); #1;
        buttons2 = '0; btn2 = 1'b0; load2 = 1'b0;
        mcur2 = next_cur(mcur2, b, R2, C2);
    endtask

    task automatic goto(input int t);
        while (mcur != t) step(4'b1000, 1'b0, 1'b0);
    endtask

    task automatic goto2(input int t);
        while (mcur2 != t) step2(4'b1000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'd0);
        sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'd0);
        rst_n = 1'b0; rst_n2 = 1'b0;
        buttons = 4'b1111; btn = 1'b1; load = 1'b1; load_data = '1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; rst_n2 = 1'b1;
        buttons = '0; btn = 1'b0; load = 1'b0;
        mcur = 0; mcount = 0; mcur2 = 0; mcount2 = 0;
        for (int i = 0; i < N; i++) mg[i] = 0;
        for (int i = 0; i < N2; i++) mg2[i] = 0;
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL reset_status got=%0h want=%0h", status, e); end
        e = sb.pop_front(); vectors++;
        if (64'(cursor) !== e) begin miscompares++; $display("FAIL reset_cursor got=%0h want=%0h", cursor, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL reset_sel_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL reset_sel_index got=%0h want=%0h", sel_index, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL reset_done got=%0h want=%0h", merge_done, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_count) !== e) begin miscompares++; $display("FAIL reset_count got=%0h want=%0h", merge_count, e); end
    endtask

    task automatic test_merge();
        for (int i = 0; i < N; i++) mg[i] = i;
        mg[3] = 7; mg[8] = 5;
        load_data = pack1();
        sb.push_back(64'(pack1()));
        step(4'b0000, 1'b0, 1'b1);
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL load_status got=%0h want=%0h", status, e); end

        goto(3);
        sb.push_back(64'd1); sb.push_back(64'd3);
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL select_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL select_index got=%0h want=%0h", sel_index, e); end

        goto(8);
        mg[3] = (mg[3] + mg[8]) % 10;
`ifdef CARD_CLEAR_EN
        mg[8] = 0;
        sb.push_back(64'd0);
`else
        sb.push_back(64'd5);
`endif
        mcount = 1;
        sb.push_back(64'd2); sb.push_back(64'(pack1()));
        sb.push_back(64'd1); sb.push_back(64'd1); sb.push_back(64'd0);
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(status[32 +: 4]) !== e) begin miscompares++; $display("FAIL merge_cell8 got=%0h want=%0h", status[32 +: 4], e); end
        e = sb.pop_front(); vectors++;
        if (64'(status[12 +: 4]) !== e) begin miscompares++; $display("FAIL merge_cell3 got=%0h want=%0h", status[12 +: 4], e); end
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL merge_status got=%0h want=%0h", status, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL merge_done got=%0h want=%0h", merge_done, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_count) !== e) begin miscompares++; $display("FAIL merge_count got=%0h want=%0h", merge_count, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL merge_sel_valid got=%0h want=%0h", sel_valid, e); end

        sb.push_back(64'd0);
        step(4'b0000, 1'b0, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL done_pulse_width got=%0h want=%0h", merge_done, e); end
    endtask

    task automatic test_cursor();
        logic [3:0] mv [4];
        logic [63:0] want [4];
        mv[0] = 4'b0100; want[0] = 64'd9;
        mv[1] = 4'b1000; want[1] = 64'd0;
        mv[2] = 4'b0001; want[2] = 64'd5;
        mv[3] = 4'b0010; want[3] = 64'd2;
        goto(0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) goto(7);
            sb.push_back(want[i]);
            step(mv[i], 1'b0, 1'b0);
            e = sb.pop_front(); vectors++;
            if (64'(cursor) !== e) begin miscompares++; $display("FAIL cursor_move%0d got=%0h want=%0h", i, cursor, e); end
        end
    endtask

    task automatic test_cancel();
        goto(4);
        sb.push_back(64'd1); sb.push_back(64'd4);
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL cancel_sel_valid1 got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL cancel_sel_index got=%0h want=%0h", sel_index, e); end
        sb.push_back(64'd0); sb.push_back(64'(pack1()));
        sb.push_back(64'd0); sb.push_back(64'(mcount));
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL cancel_sel_valid0 got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL cancel_status got=%0h want=%0h", status, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL cancel_done got=%0h want=%0h", merge_done, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_count) !== e) begin miscompares++; $display("FAIL cancel_count got=%0h want=%0h", merge_count, e); end
    endtask

    task automatic test_priority();
        goto(1);
        sb.push_back(64'd6);
        step(4'b1010, 1'b0, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(cursor) !== e) begin miscompares++; $display("FAIL priority_cursor got=%0h want=%0h", cursor, e); end
        goto(1);
        sb.push_back(64'd1); sb.push_back(64'd2); sb.push_back(64'd1);
        step(4'b1000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL btnmove_sel_index got=%0h want=%0h", sel_index, e); end
        e = sb.pop_front(); vectors++;
        if (64'(cursor) !== e) begin miscompares++; $display("FAIL btnmove_cursor got=%0h want=%0h", cursor, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL btnmove_sel_valid got=%0h want=%0h", sel_valid, e); end
    endtask

    task automatic test_load_in_held();
        for (int i = 0; i < N; i++) mg[i] = (3 * i + 1) % 16;
        load_data = pack1();
        sb.push_back(64'(pack1())); sb.push_back(64'd0);
        sb.push_back(64'd0); sb.push_back(64'(mcount));
        step(4'b0000, 1'b1, 1'b1);
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL loadheld_status got=%0h want=%0h", status, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL loadheld_sel_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL loadheld_done got=%0h want=%0h", merge_done, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_count) !== e) begin miscompares++; $display("FAIL loadheld_count got=%0h want=%0h", merge_count, e); end
        sb.push_back(64'd1); sb.push_back(64'(mcur));
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL afterload_sel_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL afterload_sel_index got=%0h want=%0h", sel_index, e); end
    endtask

    task automatic test_reset_mid_held();
        sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'd0);
        sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'd0);
        rst_n = 1'b0; buttons = 4'b0001; btn = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; buttons = '0; btn = 1'b0;
        mcur = 0; mcount = 0;
        for (int i = 0; i < N; i++) mg[i] = 0;
        e = sb.pop_front(); vectors++;
        if (64'(status) !== e) begin miscompares++; $display("FAIL midreset_status got=%0h want=%0h", status, e); end
        e = sb.pop_front(); vectors++;
        if (64'(cursor) !== e) begin miscompares++; $display("FAIL midreset_cursor got=%0h want=%0h", cursor, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL midreset_sel_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL midreset_sel_index got=%0h want=%0h", sel_index, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL midreset_done got=%0h want=%0h", merge_done, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_count) !== e) begin miscompares++; $display("FAIL midreset_count got=%0h want=%0h", merge_count, e); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) mg[i] = i + 3;
        load_data = pack1();
        step(4'b0000, 1'b0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            step(4'b0000, 1'b1, 1'b0);
            step(4'b1000, 1'b0, 1'b0);
            mg[m] = (mg[m] + mg[m + 1]) % 10;
`ifdef CARD_CLEAR_EN
            mg[m + 1] = 0;
`endif
            mcount++;
            sb.push_back(64'(pack1())); sb.push_back(64'd1); sb.push_back(64'(mcount));
            step(4'b0000, 1'b1, 1'b0);
            e = sb.pop_front(); vectors++;
            if (64'(status) !== e) begin miscompares++; $display("FAIL b2b_status%0d got=%0h want=%0h", m, status, e); end
            e = sb.pop_front(); vectors++;
            if (64'(merge_done) !== e) begin miscompares++; $display("FAIL b2b_done%0d got=%0h want=%0h", m, merge_done, e); end
            e = sb.pop_front(); vectors++;
            if (64'(merge_count) !== e) begin miscompares++; $display("FAIL b2b_count%0d got=%0h want=%0h", m, merge_count, e); end
        end
        // Immediate re-select after the second merge: the FSM is already idle.
        sb.push_back(64'd1); sb.push_back(64'(mcur)); sb.push_back(64'd0);
        step(4'b0000, 1'b1, 1'b0);
        e = sb.pop_front(); vectors++;
        if (64'(sel_valid) !== e) begin miscompares++; $display("FAIL b2b_reselect_valid got=%0h want=%0h", sel_valid, e); end
        e = sb.pop_front(); vectors++;
        if (64'(sel_index) !== e) begin miscompares++; $display("FAIL b2b_reselect_index got=%0h want=%0h", sel_index, e); end
        e = sb.pop_front(); vectors++;
        if (64'(merge_done) !== e) begin miscompares++; $display("FAIL b2b_done_cleared got=%0h want=%0h", merge_done, e); end
    endtask

    task automatic test_param2();
        logic [63:0] fixed [4];
        fixed[0] = 64'd14; fixed[1] = 64'd11; fixed[2] = '0; fixed[3] = '0;
        for (int i = 0; i < N2; i++) mg2[i] = (7 * i) % 32;
        mg2[0] = 15; mg2[1] = 16; mg2[2] = 31; mg2[3] = 31;
        load_data2 = pack2();
        step2(4'b0000, 1'b0, 1'b1);
        for (int m = 0; m < 4; m++) begin
            goto2(2 * m);
            step2(4'b0000, 1'b1, 1'b0);
            step2(4'b1000, 1'b0, 1'b0);
            mg2[2 * m] = (mg2[2 * m] + mg2[2 * m + 1]) % 17;
`ifdef CARD_CLEAR_EN
            mg2[2 * m + 1] = 0;
`endif
            mcount2 = (mcount2 < 3) ? mcount2 + 1 : 3;
            sb.push_back(64'(pack2())); sb.push_back(64'(mcount2)); sb.push_back(64'd1);
            step2(4'b0000, 1'b1, 1'b0);
            e = sb.pop_front(); vectors++;
            if (64'(status2) !== e) begin miscompares++; $display("FAIL p2_status%0d got=%0h want=%0h", m, status2, e); end
            e = sb.pop_front(); vectors++;
            if (64'(merge_count2) !== e) begin miscompares++; $display("FAIL p2_count%0d got=%0h want=%0h", m, merge_count2, e); end
            e = sb.pop_front(); vectors++;
            if (64'(merge_done2) !== e) begin miscompares++; $display("FAIL p2_done%0d got=%0h want=%0h", m, merge_done2, e); end
            if (m < 2) begin
                sb.push_back(fixed[m]);
                e = sb.pop_front(); vectors++;
                if (64'(status2[10 * m +: 5]) !== e) begin miscompares++; $display("FAIL p2_cell%0d got=%0h want=%0h", 2 * m, status2[10 * m +: 5], e); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; btn = 1'b0; load = 1'b0; buttons = '0; load_data = '0;
        rst_n2 = 1'b1; btn2 = 1'b0; load2 = 1'b0; buttons2 = '0; load_data2 = '0;
        @(posedge clk); #1;
        test_reset();
        test_merge();
        test_cursor();
        test_cancel();
        test_priority();
        test_load_in_held();
        test_reset_mid_held();
        test_back_to_back();
        test_param2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
